conv_tile_mac_sequencer: RTL and testbench
==========================================

// Module: conv_tile_mac_sequencer
// PURPOSE
//  Control FSM for one output-tile pass through complexMultArrayParallel -> complexAccumulatorArrayParallel.
//  Per command, feeds NUM input-channel beats (4 image tiles + 1 kernel each) into the multiplier array.
//  Tracks products through the multiplier pipeline; frames them for the accumulators with start/stop.
//  Waits for the accumulated result and hands it downstream. Issues control only; no complex data passes through.
// PARAMETERS
//  CH_W        10   width of channel-count field (max 2^CH_W-1 channels per tile)
//  MULT_LAT    12   multiplier next->next_out latency, in cycles (must be >= 1)
//  ACC_TIMEOUT 64   max cycles in WAIT_ACC before the timeout error fires (must be >= 2)
// PORTS
//  clk               in   1     clock
//  reset             in   1     reset
//  cmd_valid         in   1     tile command valid
//  cmd_ready         out  1     sequencer can accept a command (high only in IDLE)
//  cmd_num_ch        in   CH_W  input channels to accumulate for this tile
//  in_valid          in   1     upstream buffer presents a channel beat (image+kernel)
//  in_ready          out  1     beat consumed this cycle when in_valid & in_ready
//  mult_next         out  1     drives complexMultArrayParallel.next
//  mult_zero         out  1     input-mux select: present zero operands this cycle
//  mult_next_out     in   1     complexMultArrayParallel.next_out (alignment check)
//  acc_start         out  1     drives accumulator start (first product of tile)
//  acc_stop          out  1     drives accumulator stop (last product of tile)
//  acc_output_valid  in   1     accumulator result valid
//  out_valid         out  1     tile result available on accumulator outputs
//  out_ready         in   1     downstream takes result
//  out_empty         out  1     qualifies out_valid: tile had 0 channels, data meaningless
//  busy              out  1     FSM not in IDLE
//  err_timeout       out  1     sticky: accumulator never answered
//  err_align         out  1     sticky: mult_next_out disagreed with internal tag pipe
//  clr_err           in   1     synchronous clear of both sticky errors
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  - reset is active low: reset==0 asynchronously forces all state and outputs to 0, FSM to IDLE.
//  - Outputs during and after reset: cmd_ready rises in the first cycle after reset deasserts.
//  FSM states and transitions:
//  - IDLE: cmd_ready=1.
//    On cmd_valid, latch num=cmd_num_ch and clear ch_cnt.
//    If num==0, go to OUTPUT with out_empty=1. Otherwise go to FEED.
//  - FEED: in_ready=1 every cycle. Each cycle, exactly one slot is issued to the multiplier:
//    - in_valid=1: real beat. mult_next=1, mult_zero=0, ch_cnt++.
//    - in_valid=0: bubble, zero-filled. mult_next=1, mult_zero=1, ch_cnt unchanged.
//      Zero products leave the accumulated sum unchanged, so the accumulator sees a gapless stream.
//    - Leaving FEED: go to DRAIN when the beat taking ch_cnt to num is accepted.
//  - Tag pipe: a MULT_LAT-deep shift register of {v, first, last} per slot.
//    - first = first issued slot of the tile (may be a zero slot).
//    - last = slot carrying beat num.
//    - At the pipe tail, acc_start=v&first and acc_stop=v&last, both as 1-cycle pulses.
//    - If the tile has one slot, start and stop pulse in the same cycle.
//  - DRAIN: in_ready=0, mult_next=0. Go to WAIT_ACC in the cycle after the last tag leaves the tail.
//  - WAIT_ACC: go to OUTPUT on acc_output_valid.
//    A counter runs from WAIT_ACC entry; if it reaches ACC_TIMEOUT, set err_timeout and go to OUTPUT.
//  - OUTPUT: out_valid=1, held until out_ready. On out_ready, clear out_valid/out_empty and go to IDLE.
//  Alignment check and error handling:
//  - Every cycle, mult_next_out != tail v sets err_align.
//  - err_align is a flag only; the FSM continues.
//  - clr_err clears errors. If clr_err coincides with a new error, the set wins.
//  Boundary cases:
//  - Minimum latency for num=N with no bubbles: cmd accept -> acc_stop takes 1+N-1+MULT_LAT cycles.
//  - Back-to-back commands: the next command is accepted only after result handoff.
//    This guarantees accumulator outputs are stable while out_valid is high.
//  - num at its maximum (2^CH_W-1): ch_cnt is CH_W bits and never wraps, because the exit compare happens on equality.
//  - acc_output_valid outside WAIT_ACC is ignored.
//  - cmd_valid outside IDLE is ignored, since cmd_ready=0.
// TESTING
//  T1 reset: hold reset=0 with random inputs -> all outputs 0. Release -> cmd_ready=1 next cycle.
//  T2 num=3, in_valid always 1, MULT_LAT=12:
//     - mult_next high for 3 cycles.
//     - acc_start 12 cycles after the first beat; acc_stop 2 cycles later.
//     - Return acc_output_valid 5 cycles later -> out_valid until out_ready.
//  T3 num=4 with bubbles on beats 2 and 3 -> 6 slots issued with mult_zero=1 on 2 of them.
//     acc_start to acc_stop spans 6 cycles; ch_cnt ends at 4.
//  T4 num=1 -> acc_start and acc_stop in the same cycle.
//     num=0 -> out_valid=1, out_empty=1, mult_next never pulses.
//  T5 never return acc_output_valid -> err_timeout=1 after 64 WAIT_ACC cycles, out_valid=1.
//     Then clr_err -> err_timeout=0.
//  T6 delay mult_next_out one cycle vs tags -> err_align=1. Assert reset mid-FEED -> IDLE, no stray pulses.

Source files
------------

// File: rtl/conv_tile_mac_sequencer.sv
// Control sequencer for one output-tile pass: feeds channel beats into the complex
// multiplier array, frames products for the accumulator and hands the result downstream.
module conv_tile_mac_sequencer #(
  parameter int CH_W        = 10,
  parameter int MULT_LAT    = 12,
  parameter int ACC_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [CH_W-1:0] cmd_num_ch,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            mult_next,
  output logic            mult_zero,
  input  logic            mult_next_out,
  output logic            acc_start,
  output logic            acc_stop,
  input  logic            acc_output_valid,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_empty,
  output logic            busy,
  output logic            err_timeout,
  output logic            err_align,
  input  logic            clr_err
);

  localparam int WAIT_W = $clog2(ACC_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_WAIT_ACC,
    S_OUTPUT
  } state_t;

  state_t state_q, state_d;

  logic [CH_W-1:0]     num_q;
  logic [CH_W-1:0]     ch_cnt_q;
  logic [CH_W-1:0]     ch_cnt_inc;
  logic                first_pending_q;
  logic [MULT_LAT-1:0] tag_v_q;
  logic [MULT_LAT-1:0] tag_first_q;
  logic [MULT_LAT-1:0] tag_last_q;
  logic                tail_v;
  logic                tail_first;
  logic                tail_last;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                armed_q;
  logic                out_empty_q;
  logic                err_timeout_q;
  logic                err_align_q;

  logic accept;
  logic issue;
  logic beat;
  logic head_last;
  logic timeout_hit;
  logic handoff;

  assign ch_cnt_inc = ch_cnt_q + CH_W'(1);
  assign tail_v     = tag_v_q[MULT_LAT-1];
  assign tail_first = tag_first_q[MULT_LAT-1];
  assign tail_last  = tag_last_q[MULT_LAT-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A slot is issued every FEED cycle; bubbles become zero operands so the
  // accumulator always sees a gapless product stream.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    issue       = 1'b0;
    beat        = 1'b0;
    head_last   = 1'b0;
    timeout_hit = 1'b0;
    handoff     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && armed_q) begin
          accept  = 1'b1;
          state_d = (cmd_num_ch == '0) ? S_OUTPUT : S_FEED;
        end
      end
      S_FEED: begin
        issue = 1'b1;
        if (in_valid) begin
          beat = 1'b1;
          if (ch_cnt_inc == num_q) begin
            head_last = 1'b1;
            state_d   = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (tail_v && tail_last) begin
          state_d = S_WAIT_ACC;
        end
      end
      S_WAIT_ACC: begin
        if (acc_output_valid) begin
          state_d = S_OUTPUT;
        end else if (wait_cnt_q == WAIT_W'(ACC_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          handoff = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready = (state_q == S_IDLE) && armed_q;
    in_ready  = issue;
    mult_next = issue;
    mult_zero = issue && !in_valid;
    out_valid = (state_q == S_OUTPUT);
    busy      = (state_q != S_IDLE);
  end

  // armed_q keeps cmd_ready low while reset is held and for the release cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_q         <= 1'b0;
      num_q           <= '0;
      ch_cnt_q        <= '0;
      first_pending_q <= 1'b0;
      out_empty_q     <= 1'b0;
      wait_cnt_q      <= '0;
    end else begin
      armed_q <= 1'b1;
      if (accept) begin
        num_q           <= cmd_num_ch;
        ch_cnt_q        <= '0;
        first_pending_q <= 1'b1;
        out_empty_q     <= (cmd_num_ch == '0);
      end else begin
        if (beat) begin
          ch_cnt_q <= ch_cnt_inc;
        end
        if (issue) begin
          first_pending_q <= 1'b0;
        end
        if (handoff) begin
          out_empty_q <= 1'b0;
        end
      end
      if (state_q != S_WAIT_ACC) begin
        wait_cnt_q <= '0;
      end else begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end
    end
  end

  // Tag pipe mirrors the multiplier latency so framing lines up with products.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_v_q     <= '0;
      tag_first_q <= '0;
      tag_last_q  <= '0;
    end else begin
      tag_v_q[0]     <= issue;
      tag_first_q[0] <= issue && first_pending_q;
      tag_last_q[0]  <= head_last;
      for (int i = 1; i < MULT_LAT; i++) begin
        tag_v_q[i]     <= tag_v_q[i-1];
        tag_first_q[i] <= tag_first_q[i-1];
        tag_last_q[i]  <= tag_last_q[i-1];
      end
    end
  end

  // Sticky errors: a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_timeout_q <= 1'b0;
      err_align_q   <= 1'b0;
    end else begin
      if (timeout_hit) begin
        err_timeout_q <= 1'b1;
      end else if (clr_err) begin
        err_timeout_q <= 1'b0;
      end
      if (mult_next_out != tail_v) begin
        err_align_q <= 1'b1;
      end else if (clr_err) begin
        err_align_q <= 1'b0;
      end
    end
  end

  assign acc_start   = tail_v && tail_first;
  assign acc_stop    = tail_v && tail_last;
  assign out_empty   = out_empty_q;
  assign err_timeout = err_timeout_q;
  assign err_align   = err_align_q;

endmodule

// File: tb/tb_conv_tile_mac_sequencer.sv
// Directed bench for conv_tile_mac_sequencer: a multiplier latency model plus a
// scoreboard of expected acc_start/acc_stop cycles and out_empty values at handoff.
module tb_conv_tile_mac_sequencer;

  localparam int CH_W        = 10;
  localparam int MULT_LAT    = 12;
  localparam int ACC_TIMEOUT = 64;

  logic            clk;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [CH_W-1:0] cmd_num_ch;
  logic            in_valid;
  logic            in_ready;
  logic            mult_next;
  logic            mult_zero;
  logic            mult_next_out;
  logic            acc_start;
  logic            acc_stop;
  logic            acc_output_valid;
  logic            out_valid;
  logic            out_ready;
  logic            out_empty;
  logic            busy;
  logic            err_timeout;
  logic            err_align;
  logic            clr_err;

  conv_tile_mac_sequencer #(
    .CH_W(CH_W),
    .MULT_LAT(MULT_LAT),
    .ACC_TIMEOUT(ACC_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_num_ch(cmd_num_ch),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mult_next(mult_next),
    .mult_zero(mult_zero),
    .mult_next_out(mult_next_out),
    .acc_start(acc_start),
    .acc_stop(acc_stop),
    .acc_output_valid(acc_output_valid),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_empty(out_empty),
    .busy(busy),
    .err_timeout(err_timeout),
    .err_align(err_align),
    .clr_err(clr_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int next_cnt = 0;
  int zero_cnt = 0;
  int exp_start_q[$];
  int exp_stop_q[$];
  bit exp_empty_q[$];
  logic skew = 1'b0;
  logic [MULT_LAT:0] mnpipe;
  logic [10:0] all_outs;

  assign all_outs = {cmd_ready, in_ready, mult_next, mult_zero, acc_start, acc_stop,
                     out_valid, out_empty, busy, err_timeout, err_align};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  // Multiplier model: next_out follows next by MULT_LAT cycles (one more when skewed).
  always @(posedge clk or negedge reset) begin
    if (!reset) mnpipe <= '0;
    else        mnpipe <= {mnpipe[MULT_LAT-1:0], mult_next};
  end
  assign mult_next_out = skew ? mnpipe[MULT_LAT] : mnpipe[MULT_LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Scoreboard consumer: every framing pulse and handoff must match a queued expectation.
  always @(negedge clk) begin
    int e;
    bit eb;
    if (reset) begin
      if (mult_next) next_cnt++;
      if (mult_zero) zero_cnt++;
      if (acc_start) begin
        check("acc_start_pending", exp_start_q.size() > 0, 1);
        if (exp_start_q.size() > 0) begin
          e = exp_start_q.pop_front();
          check("acc_start_cycle", cyc, e);
        end
      end
      if (acc_stop) begin
        check("acc_stop_pending", exp_stop_q.size() > 0, 1);
        if (exp_stop_q.size() > 0) begin
          e = exp_stop_q.pop_front();
          check("acc_stop_cycle", cyc, e);
        end
      end
      if (out_valid && out_ready) begin
        check("handoff_pending", exp_empty_q.size() > 0, 1);
        if (exp_empty_q.size() > 0) begin
          eb = exp_empty_q.pop_front();
          check("handoff_out_empty", out_empty, eb);
        end
      end
    end
  end

  // Issues a command and its channel beats; mask bit s set means slot s is a bubble.
  task automatic applyStimulus(input int num, input logic [31:0] mask, output int stop_cyc);
    int acc;
    int s;
    int beats;
    bit iv;
    step();
    cmd_valid  = 1'b1;
    cmd_num_ch = CH_W'(num);
    settle();
    check("cmd_ready_at_accept", cmd_ready, 1);
    acc = cyc;
    exp_empty_q.push_back(num == 0);
    step();
    cmd_valid = 1'b0;
    stop_cyc  = acc;
    if (num == 0) return;
    exp_start_q.push_back(acc + 1 + MULT_LAT);
    s     = 0;
    beats = 0;
    forever begin
      iv = (s < 32) ? !mask[s] : 1'b1;
      in_valid = iv;
      settle();
      if (s < 8) begin
        check("feed_mult_next", mult_next, 1);
        check("feed_mult_zero", mult_zero, !iv);
      end
      s++;
      if (iv) beats++;
      if (beats == num) break;
      step();
    end
    exp_stop_q.push_back(acc + s + MULT_LAT);
    stop_cyc = acc + s + MULT_LAT;
    step();
    in_valid = 1'b0;
    settle();
    check("drain_mult_next", mult_next, 0);
    check("drain_in_ready", in_ready, 0);
  endtask

  // Called in the first OUTPUT cycle: result held until out_ready, then back to IDLE.
  task automatic checkOutput();
    check("out_valid_rise", out_valid, 1);
    step();
    settle();
    check("out_valid_held", out_valid, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    settle();
    check("out_valid_cleared", out_valid, 0);
    check("out_empty_cleared", out_empty, 0);
    check("cmd_ready_after_handoff", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int stop;
    int n0;
    int z0;
    reset            = 1'b0;
    cmd_valid        = 1'b0;
    cmd_num_ch       = '0;
    in_valid         = 1'b0;
    acc_output_valid = 1'b0;
    out_ready        = 1'b0;
    clr_err          = 1'b0;

    $display("[TB] T1 reset");
    for (int i = 0; i < 6; i++) begin
      step();
      cmd_valid        = 1'($urandom_range(0, 1));
      cmd_num_ch       = CH_W'($urandom_range(0, 1023));
      in_valid         = 1'($urandom_range(0, 1));
      acc_output_valid = 1'($urandom_range(0, 1));
      out_ready        = 1'($urandom_range(0, 1));
      clr_err          = 1'($urandom_range(0, 1));
      settle();
      check("reset_outputs_zero", all_outs, 0);
    end
    step();
    cmd_valid = 1'b0; cmd_num_ch = '0; in_valid = 1'b0;
    acc_output_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    reset = 1'b1;
    settle();
    check("cmd_ready_release_cycle", cmd_ready, 0);
    step();
    settle();
    check("cmd_ready_after_release", cmd_ready, 1);
    check("busy_idle", busy, 0);

    $display("[TB] T2 num=3 no bubbles");
    n0 = next_cnt; z0 = zero_cnt;
    applyStimulus(3, 32'h0, stop);
    wait_until(stop + 5);
    acc_output_valid = 1'b1;
    settle();
    check("t2_wait_no_out", out_valid, 0);
    check("t2_busy", busy, 1);
    step();
    acc_output_valid = 1'b0;
    settle();
    check("t2_out_empty", out_empty, 0);
    checkOutput();
    check("t2_slots", next_cnt - n0, 3);
    check("t2_zeros", zero_cnt - z0, 0);

    $display("[TB] T3 num=4 with two bubbles");
    step();
    acc_output_valid = 1'b1;
    step();
    acc_output_valid = 1'b0;
    settle();
    check("t3_stray_acc_valid", out_valid, 0);
    n0 = next_cnt; z0 = zero_cnt;
    applyStimulus(4, 32'b001010, stop);
    wait_until(stop + 1);
    acc_output_valid = 1'b1;
    settle();
    check("t3_wait_no_out", out_valid, 0);
    step();
    acc_output_valid = 1'b0;
    settle();
    checkOutput();
    check("t3_slots", next_cnt - n0, 6);
    check("t3_zeros", zero_cnt - z0, 2);

    $display("[TB] T4 num=1 and num=0");
    applyStimulus(1, 32'h0, stop);
    wait_until(stop + 2);
    acc_output_valid = 1'b1;
    step();
    acc_output_valid = 1'b0;
    settle();
    checkOutput();
    applyStimulus(1, 32'b1, stop);
    wait_until(stop + 3);
    acc_output_valid = 1'b1;
    step();
    acc_output_valid = 1'b0;
    settle();
    checkOutput();
    n0 = next_cnt;
    applyStimulus(0, 32'h0, stop);
    settle();
    check("t4_empty_flag", out_empty, 1);
    checkOutput();
    check("t4_empty_no_slots", next_cnt - n0, 0);

    $display("[TB] T5 accumulator timeout");
    applyStimulus(2, 32'h0, stop);
    wait_until(stop + ACC_TIMEOUT);
    settle();
    check("t5_last_wait_no_out", out_valid, 0);
    check("t5_last_wait_no_err", err_timeout, 0);
    step();
    settle();
    check("t5_timeout_err", err_timeout, 1);
    checkOutput();
    check("t5_err_sticky", err_timeout, 1);
    step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    settle();
    check("t5_err_cleared", err_timeout, 0);
    check("t5_no_align_err", err_align, 0);

    $display("[TB] T6 misalignment and reset mid-FEED");
    skew = 1'b1;
    applyStimulus(2, 32'h0, stop);
    wait_until(stop - 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    settle();
    check("t6_align_set_wins", err_align, 1);
    wait_until(stop + 3);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    skew = 1'b0;
    acc_output_valid = 1'b1;
    settle();
    check("t6_align_cleared", err_align, 0);
    step();
    acc_output_valid = 1'b0;
    settle();
    checkOutput();
    step();
    cmd_valid  = 1'b1;
    cmd_num_ch = CH_W'(5);
    step();
    cmd_valid = 1'b0;
    in_valid  = 1'b1;
    step();
    step();
    reset = 1'b0;
    settle();
    check("t6_reset_outputs_zero", all_outs, 0);
    step();
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    settle();
    check("t6_idle_after_reset", cmd_ready, 1);
    check("t6_not_busy", busy, 0);
    for (int i = 0; i < 20; i++) step();
    check("t6_no_stray_slots", mult_next, 0);
    check("t6_align_clean", err_align, 0);

    $display("[TB] T7 maximum channel count");
    n0 = next_cnt;
    applyStimulus(1023, 32'h0, stop);
    wait_until(stop + 3);
    acc_output_valid = 1'b1;
    step();
    acc_output_valid = 1'b0;
    settle();
    checkOutput();
    check("t7_slots", next_cnt - n0, 1023);

    step();
    check("start_queue_drained", exp_start_q.size(), 0);
    check("stop_queue_drained", exp_stop_q.size(), 0);
    check("handoff_queue_drained", exp_empty_q.size(), 0);
    check("final_errors_clear", {err_timeout, err_align}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
